seven_seg_scan: RTL
===================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port value  input  4*N_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
REQ-006 SHALL have port dp_in  input  N_DIGITS  decimal point request per digit, active-high.
REQ-007 SHALL have port digit_en  input  N_DIGITS  per-digit enable; 0 = digit dark.
REQ-008 SHALL have port seg  output  7  segments {a,b,c,d,e,f,g} on seg[6:0], active-low.
REQ-009 SHALL have port dp  output  1  decimal point, active-low.
REQ-010 SHALL have port an  output  N_DIGITS  digit anodes, active-low, at most one low.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse when a new snapshot is taken.

Function
REQ-012 SHALL run prescaler cnt 0..REFRESH_DIV-1, wrapping; tick = (cnt == REFRESH_DIV-1).
REQ-013 SHALL advance digit index idx by 1 on tick, wrapping N_DIGITS-1 -> 0; N_DIGITS=1 keeps idx at 0.
REQ-014 SHALL capture value, dp_in, digit_en into shadow registers on the tick where idx wraps to 0 (every tick when N_DIGITS=1); inputs between snapshots have no effect.
REQ-015 SHALL assert frame_start for exactly the cycle after the snapshot edge.
REQ-016 SHALL register seg, dp, an every cycle from the current idx and shadows: one-cycle latency from idx change to outputs.
REQ-017 SHALL drive an[idx]=0, all other an bits 1, when shadow digit_en[idx]=1; all an=1 otherwise.
REQ-018 SHALL drive seg = bitwise NOT of active-high glyph (hex, abcdefg): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:73 A:77 b:1F C:4E d:3D E:4F F:47.
REQ-019 SHALL drive dp = NOT shadow dp_in[idx] when digit enabled; dp=1 when disabled.
REQ-020 SHALL drive seg=7'h7F and dp=1 whenever an is all ones.
REQ-021 SHALL use a prescaler width of clog2(REFRESH_DIV) (min 1) and idx width clog2(N_DIGITS) (min 1); no overflow beyond stated wrap points.

Reset
REQ-022 SHALL, while reset=1 at a clock edge, set cnt=0, idx=0, all shadows=0, seg=7'h7F, dp=1, an all ones, frame_start=0.
REQ-023 SHALL, when reset asserts mid-scan, abandon the frame; first snapshot after release occurs after N_DIGITS*REFRESH_DIV cycles.
REQ-024 SHALL ignore inputs during reset; reset has priority over tick.

Configuration
REQ-025 SHALL, with macro SEVEN_SEG_LZB_EN defined, blank leading zeros: digit i (i>0) shows seg=7'h7F when shadow nibbles i..N_DIGITS-1 are all zero; an and dp unaffected; digit 0 never blanked.
REQ-026 SHALL, without SEVEN_SEG_LZB_EN, display every enabled digit per REQ-018 with no zero suppression.

Verification (N_DIGITS=4, REFRESH_DIV=4)
REQ-027 SHALL cover: reset 3 cycles -> an=4'hF, seg=7'h7F, dp=1, frame_start=0 throughout; first frame_start 16 cycles after release.
REQ-028 SHALL cover: value=16'h12AF, digit_en=4'hF, dp_in=4'b0100 -> per slot an=E,D,B,7 with seg=~47,~77,~6D,~30; dp=0 only when an=B.
REQ-029 SHALL cover: value changed mid-frame -> displayed digits unchanged until next frame_start, then new value shown.
REQ-030 SHALL cover: digit_en=4'b1010 -> an stays F and seg=7'h7F during slots 0 and 2.
REQ-031 SHALL cover: SEVEN_SEG_LZB_EN defined, value=16'h0050 -> digits 3,2 seg=7'h7F with an active; digit1 seg=~5B; digit0 seg=~7E; undefined -> digits 3,2 seg=~7E.
REQ-032 SHALL cover: reset pulsed one cycle during slot 2 -> idx restarts at 0, an=F for one cycle, cnt restarts from 0.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver. It takes a snapshot of value, dp_in and
// digit_en once per frame. Define SEVEN_SEG_LZB_EN to blank leading zeros.
module seven_seg_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] val_q;
  logic [N_DIGITS-1:0]   dpin_q;
  logic [N_DIGITS-1:0]   en_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  fs_q;
  logic                  tick, snap;
  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   blank;

  // Active-high glyphs, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h7E;
      4'h1: glyph = 7'h30;
      4'h2: glyph = 7'h6D;
      4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;
      4'h5: glyph = 7'h5B;
      4'h6: glyph = 7'h5F;
      4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h73;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;
      4'hD: glyph = 7'h3D;
      4'hE: glyph = 7'h4F;
      default: glyph = 7'h47;
    endcase
  endfunction

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    snap  = tick && (idx_q == IDX_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

`ifdef SEVEN_SEG_LZB_EN
  logic zero_run;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (val_q[4*i +: 4] == 4'h0);
      if (i > 0) blank[i] = zero_run;
    end
  end
`else
  always_comb blank = '0;
`endif

  always_comb begin
    nib   = val_q[4*idx_q +: 4];
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en_q[idx_q]) begin
      an_d[idx_q] = 1'b0;
      dp_d        = ~dpin_q[idx_q];
      if (!blank[idx_q]) seg_d = ~glyph(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dpin_q <= '0;
      en_q   <= '0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= '1;
      fs_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (snap) begin
        val_q  <= value;
        dpin_q <= dp_in;
        en_q   <= digit_en;
      end
      fs_q  <= snap;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule
